avalon_mem_model: RTL



---
 rtl/avalon_mem_pkg.sv | 45 ++++
 rtl/avalon_mem_if.sv | 27 ++
 rtl/avalon_mem_lfsr.sv | 28 ++
 rtl/avalon_mem_model.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/avalon_mem_pkg.sv
// Shared types, constants and address decode for the Avalon-MM memory model.
package avalon_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } mem_state_t;

  // Stall generator: 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10).
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic        hit;
    logic [31:0] idx;
  } decode_t;

  // Map a bus byte address onto the backing array. A miss covers both
  // addresses outside the two windows and addresses not aligned to the bus.
  function automatic decode_t decode_addr(
    input logic [31:0] address,
    input logic [31:0] mem_bytes,
    input logic [31:0] vec_base,
    input logic [31:0] vec_bytes,
    input logic [31:0] vec_offset,
    input logic [31:0] be_w
  );
    decode_t d;
    d.hit = 1'b0;
    d.idx = '0;
    if ((address % be_w) == 32'd0) begin
      if (address < mem_bytes) begin
        d.hit = 1'b1;
        d.idx = address;
      end else if ((address >= vec_base) && ((address - vec_base) < vec_bytes)) begin
        // Subtract before comparing so the window end never overflows 32 bits.
        d.hit = 1'b1;
        d.idx = address - vec_base + vec_offset;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/avalon_mem_if.sv
// Avalon-MM slave bus bundle, including the sticky error flags.
interface avalon_mem_if #(
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic [31:0]       address;
  logic              read;
  logic              write;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              err_oob;
  logic              err_proto;

  modport master (
    output address, read, write, byteenable, writedata,
    input  waitrequest, readdata, err_oob, err_proto
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output waitrequest, readdata, err_oob, err_proto
  );

endinterface

// File: rtl/avalon_mem_lfsr.sv
// Stall-length generator: steps once per accepted request and offers its
// low two bits as 0..3 extra wait cycles.
module avalon_mem_lfsr
  import avalon_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  output logic [1:0] extra
);

  logic [15:0] lfsr_q, lfsr_d;

  // Shift left, feeding back the XOR of the tapped bits.
  always_comb begin
    lfsr_d = lfsr_q;
    if (step) lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end

  // LFSR register, reseeded on reset.
  always_ff @(posedge clk) begin
    if (!reset) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign extra = lfsr_q[1:0];

endmodule

// File: rtl/avalon_mem_model.sv
// Avalon-MM slave byte-array memory with a low data window at 0 and a
// reset-vector window aliased into the same array, fixed wait states,
// byte-lane masking and sticky error flags.
// Optional: define AVALON_MEM_RANDOM_STALL_EN to add 0..3 LFSR-driven
// extra wait cycles per request.
module avalon_mem_model
  import avalon_mem_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_BYTES    = 4096,
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter int unsigned VEC_BYTES    = 1024,
  parameter int unsigned VEC_OFFSET   = 256,
  parameter int unsigned WAIT_STATES  = 0,
  parameter string       INIT_FILE    = ""
) (
  input logic         clk,
  input logic         reset,
  avalon_mem_if.slave s
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned AW    = $clog2(MEM_BYTES);
  localparam int unsigned CNT_W = 5;

  logic [7:0] mem [MEM_BYTES];

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              waitrequest_q, waitrequest_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic              err_oob_q, err_oob_d;
  logic              err_proto_q, err_proto_d;

  logic [31:0]       addr_q, addr_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;

  logic              req;
  logic [CNT_W-1:0]  total_wait;
  logic [31:0]       op_addr;
  logic [BE_W-1:0]   op_be;
  logic [DATA_W-1:0] op_wdata;
  logic              op_rd, op_wr;
  decode_t           dec;
  logic [AW-1:0]     base_idx;
  logic              go_ack;
  logic [DATA_W-1:0] lanes;
  logic              unused_idx_hi;

  assign req = s.read | s.write;

`ifdef AVALON_MEM_RANDOM_STALL_EN
  logic [1:0] stall_extra;

  avalon_mem_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  ((state_q == IDLE) && req),
    .extra (stall_extra)
  );

  assign total_wait = CNT_W'(WAIT_STATES) + CNT_W'(stall_extra);
`else
  assign total_wait = CNT_W'(WAIT_STATES);
`endif

  // With zero wait states the transfer completes on the accepting edge, so
  // IDLE works from the live bus while later states use the latched copy.
  always_comb begin
    if (state_q == IDLE) begin
      op_addr  = s.address;
      op_be    = s.byteenable;
      op_wdata = s.writedata;
      op_rd    = s.read;
      op_wr    = s.write;
    end else begin
      op_addr  = addr_q;
      op_be    = be_q;
      op_wdata = wdata_q;
      op_rd    = rd_q;
      op_wr    = wr_q;
    end
  end

  assign dec           = decode_addr(op_addr, 32'(MEM_BYTES), RESET_VECTOR,
                                     32'(VEC_BYTES), 32'(VEC_OFFSET), 32'(BE_W));
  assign base_idx      = dec.idx[AW-1:0];
  assign unused_idx_hi = ^dec.idx[31:AW];

  // Little-endian lane gather; disabled lanes read as zero.
  always_comb begin
    lanes = '0;
    for (int k = 0; k < BE_W; k++) begin
      if (op_be[k]) lanes[8*k +: 8] = mem[base_idx + AW'(k)];
    end
  end

  // Next-state, counter and completion-side effects of the handshake FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    go_ack      = 1'b0;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    readdata_d  = readdata_q;
    err_oob_d   = err_oob_q;
    err_proto_d = err_proto_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = s.address;
          be_d    = s.byteenable;
          wdata_d = s.writedata;
          rd_d    = s.read;
          wr_d    = s.write;
          cnt_d   = total_wait;
          if (total_wait == '0) begin
            state_d = ACK;
            go_ack  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ACK;
          go_ack  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    waitrequest_d = !go_ack;

    if (go_ack) begin
      if (op_rd && op_wr) begin
        err_proto_d = 1'b1;
      end else begin
        if (!dec.hit) err_oob_d = 1'b1;
        if (op_rd) readdata_d = dec.hit ? lanes : '0;
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      waitrequest_q <= 1'b1;
      readdata_q    <= '0;
      err_oob_q     <= 1'b0;
      err_proto_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      waitrequest_q <= waitrequest_d;
      readdata_q    <= readdata_d;
      err_oob_q     <= err_oob_d;
      err_proto_q   <= err_proto_d;
    end
  end

  // Latched request fields; only meaningful while a transfer is in flight.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    be_q    <= be_d;
    wdata_q <= wdata_d;
    rd_q    <= rd_d;
    wr_q    <= wr_d;
  end

  // Byte-masked write commit on entry to ACK; reset at that edge cancels it.
  always_ff @(posedge clk) begin
    if (reset && go_ack && op_wr && !op_rd && dec.hit) begin
      for (int k = 0; k < BE_W; k++) begin
        if (op_be[k]) mem[base_idx + AW'(k)] <= op_wdata[8*k +: 8];
      end
    end
  end

  assign s.waitrequest = waitrequest_q;
  assign s.readdata    = readdata_q;
  assign s.err_oob     = err_oob_q;
  assign s.err_proto   = err_proto_q;

endmodule
